// File: rtl/packet_merge.sv
// Two-input valid/ready packet merger with a single registered output stage.
// Build option: define MERGE_FIXED_PRIORITY_EN for fixed A-over-B priority (no rr pointer).
module packet_merge #(
  parameter int PACKET_WIDTH = 160
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RECEIVE_A_VALID,
  output logic                    RECEIVE_A_READY,
  input  logic [PACKET_WIDTH-1:0] RECEIVE_A_DATA,
  input  logic                    RECEIVE_B_VALID,
  output logic                    RECEIVE_B_READY,
  input  logic [PACKET_WIDTH-1:0] RECEIVE_B_DATA,
  output logic                    SEND_PC_VALID,
  input  logic                    SEND_PC_READY,
  output logic [PACKET_WIDTH-1:0] SEND_PC_DATA
);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  logic                    out_valid_q, out_valid_d;
  logic [PACKET_WIDTH-1:0] out_data_q, out_data_d;
  logic                    load_ok;
  logic                    xfer_a, xfer_b;
  src_e                    grant;

`ifdef MERGE_FIXED_PRIORITY_EN
  // A wins whenever it is valid; with nothing valid, A is the idle preference.
  always_comb begin
    grant = SRC_A;
    if (!RECEIVE_A_VALID && RECEIVE_B_VALID) begin
      grant = SRC_B;
    end
  end
`else
  src_e rr_q, rr_d;

  always_comb begin
    grant = rr_q;
    if (RECEIVE_A_VALID && !RECEIVE_B_VALID) begin
      grant = SRC_A;
    end else if (!RECEIVE_A_VALID && RECEIVE_B_VALID) begin
      grant = SRC_B;
    end
  end

  // Pointer moves to the loser only on an accepted transfer.
  always_comb begin
    rr_d = rr_q;
    if (xfer_a) begin
      rr_d = SRC_B;
    end else if (xfer_b) begin
      rr_d = SRC_A;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_q <= SRC_A;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign load_ok         = !out_valid_q || SEND_PC_READY;
  assign RECEIVE_A_READY = !RST && load_ok && (grant == SRC_A);
  assign RECEIVE_B_READY = !RST && load_ok && (grant == SRC_B);
  assign xfer_a          = RECEIVE_A_VALID && RECEIVE_A_READY;
  assign xfer_b          = RECEIVE_B_VALID && RECEIVE_B_READY;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (xfer_a) begin
      out_valid_d = 1'b1;
      out_data_d  = RECEIVE_A_DATA;
    end else if (xfer_b) begin
      out_valid_d = 1'b1;
      out_data_d  = RECEIVE_B_DATA;
    end else if (SEND_PC_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
    end
  end

  // Payload needs no reset: it is only observed while out_valid_q is set.
  always_ff @(posedge CLK) begin
    out_data_q <= out_data_d;
  end

  // Reset masks the held packet immediately, even in the first reset cycle.
  assign SEND_PC_VALID = out_valid_q && !RST;
  assign SEND_PC_DATA  = out_data_q;

endmodule
